// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, instruction field positions
// and the control encoding loaded into EX/MEM when a bubble is inserted.
package ex_mem_stage_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SHL  = 3'b101;
    localparam logic [2:0] ALU_SHR  = 3'b110;
    localparam logic [2:0] ALU_RORC = 3'b111;

    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned IMM_MSB  = 7;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned RD_MSB   = 13;
    localparam int unsigned FLAG_BIT = 0;

    typedef struct packed {
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_write_mux;
    } ex_mem_ctrl_t;

    localparam ex_mem_ctrl_t BUBBLE_CTRL = '{mem_write: 1'b0, reg_write: 1'b0,
                                             reg_write_mux: 2'b00};

endpackage

// File: rtl/ex_mem_stage_alu8.sv
// Combinational ALU for the execute stage. Shift/rotate ops exist only when
// ALU_SHIFT_EN is defined; otherwise ops 101-111 pass A through with cout = 0.
module ex_mem_stage_alu8
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] op2,
    input  logic              cin,
    input  logic              use_carry,
    input  logic [2:0]        alu_op,
    output logic [DATA_W-1:0] res,
    output logic              cout
);

    logic          cin_eff;
    logic [DATA_W:0] wide;

    assign cin_eff = use_carry & cin;

    always_comb begin
        res  = a;
        cout = 1'b0;
        wide = '0;
        case (alu_op)
            ALU_ADD: begin
                wide = {1'b0, a} + {1'b0, op2} + {{DATA_W{1'b0}}, cin_eff};
                res  = wide[DATA_W-1:0];
                cout = wide[DATA_W];
            end
            ALU_SUB: begin
                // Bit DATA_W of the extended difference is the borrow out.
                wide = {1'b0, a} - {1'b0, op2} - {{DATA_W{1'b0}}, cin_eff};
                res  = wide[DATA_W-1:0];
                cout = wide[DATA_W];
            end
            ALU_AND: res = a & op2;
            ALU_OR:  res = a | op2;
            ALU_XOR: res = a ^ op2;
`ifdef ALU_SHIFT_EN
            ALU_SHL: begin
                res  = {a[DATA_W-2:0], 1'b0};
                cout = a[DATA_W-1];
            end
            ALU_SHR: begin
                res  = {1'b0, a[DATA_W-1:1]};
                cout = a[0];
            end
            ALU_RORC: begin
                res  = {cin, a[DATA_W-1:1]};
                cout = a[0];
            end
`endif
            default: begin
                res  = a;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM register with architectural C/Z flags, stall and flush.
// Optional shift/rotate ALU ops are enabled by defining ALU_SHIFT_EN.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INSTR_W = 19,
    parameter int unsigned RD_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  ID_EX_A,
    input  logic [DATA_W-1:0]  ID_EX_B,
    input  logic [INSTR_W-1:0] ID_EX_instruction,
    input  logic               ID_EX_mem_write,
    input  logic               ID_EX_reg_write,
    input  logic               ID_EX_alu_use_carry,
    input  logic               ID_EX_alu_in_mux,
    input  logic               ID_EX_select_c,
    input  logic               ID_EX_select_z,
    input  logic               ID_EX_write_c,
    input  logic               ID_EX_write_z,
    input  logic [2:0]         ID_EX_alu_op,
    input  logic [1:0]         ID_EX_reg_write_mux,
    output logic [DATA_W-1:0]  EX_MEM_alu_result,
    output logic [DATA_W-1:0]  EX_MEM_store_data,
    output logic [RD_W-1:0]    EX_MEM_rd,
    output logic [INSTR_W-1:0] EX_MEM_instruction,
    output logic               EX_MEM_mem_write,
    output logic               EX_MEM_reg_write,
    output logic [1:0]         EX_MEM_reg_write_mux,
    output logic               flag_c,
    output logic               flag_z
);

    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cout;
    logic              zero_next;
    logic              c_load;
    logic              z_load;

    assign imm       = DATA_W'(ID_EX_instruction[IMM_MSB:IMM_LSB]);
    assign op2       = ID_EX_alu_in_mux ? imm : ID_EX_B;
    assign zero_next = (alu_res == '0);
    assign c_load    = ID_EX_select_c ? alu_cout  : ID_EX_instruction[FLAG_BIT];
    assign z_load    = ID_EX_select_z ? zero_next : ID_EX_instruction[FLAG_BIT];

    ex_mem_stage_alu8 #(
        .DATA_W(DATA_W)
    ) u_alu (
        .a        (ID_EX_A),
        .op2      (op2),
        .cin      (flag_c),
        .use_carry(ID_EX_alu_use_carry),
        .alu_op   (ID_EX_alu_op),
        .res      (alu_res),
        .cout     (alu_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            EX_MEM_alu_result    <= '0;
            EX_MEM_store_data    <= '0;
            EX_MEM_rd            <= '0;
            EX_MEM_instruction   <= '0;
            EX_MEM_mem_write     <= 1'b0;
            EX_MEM_reg_write     <= 1'b0;
            EX_MEM_reg_write_mux <= 2'b00;
            flag_c               <= 1'b0;
            flag_z               <= 1'b0;
        end else if (flush) begin
            // Bubble wins over stall; flags are left untouched.
            EX_MEM_alu_result    <= '0;
            EX_MEM_store_data    <= '0;
            EX_MEM_rd            <= '0;
            EX_MEM_instruction   <= '0;
            EX_MEM_mem_write     <= BUBBLE_CTRL.mem_write;
            EX_MEM_reg_write     <= BUBBLE_CTRL.reg_write;
            EX_MEM_reg_write_mux <= BUBBLE_CTRL.reg_write_mux;
        end else if (!stall) begin
            EX_MEM_alu_result    <= alu_res;
            EX_MEM_store_data    <= ID_EX_B;
            EX_MEM_rd            <= ID_EX_instruction[RD_MSB:RD_LSB];
            EX_MEM_instruction   <= ID_EX_instruction;
            EX_MEM_mem_write     <= ID_EX_mem_write;
            EX_MEM_reg_write     <= ID_EX_reg_write;
            EX_MEM_reg_write_mux <= ID_EX_reg_write_mux;
            if (ID_EX_write_c) flag_c <= c_load;
            if (ID_EX_write_z) flag_z <= z_load;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; expected values are hand-computed.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [7:0]  a, b;
    logic [18:0] instr;
    logic        mem_write, reg_write, use_carry, alu_in_mux;
    logic        select_c, select_z, write_c, write_z;
    logic [2:0]  alu_op;
    logic [1:0]  rw_mux;

    logic [7:0]  o_res, o_store;
    logic [2:0]  o_rd;
    logic [18:0] o_instr;
    logic        o_mem_write, o_reg_write;
    logic [1:0]  o_rw_mux;
    logic        o_c, o_z;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .flush               (flush),
        .ID_EX_A             (a),
        .ID_EX_B             (b),
        .ID_EX_instruction   (instr),
        .ID_EX_mem_write     (mem_write),
        .ID_EX_reg_write     (reg_write),
        .ID_EX_alu_use_carry (use_carry),
        .ID_EX_alu_in_mux    (alu_in_mux),
        .ID_EX_select_c      (select_c),
        .ID_EX_select_z      (select_z),
        .ID_EX_write_c       (write_c),
        .ID_EX_write_z       (write_z),
        .ID_EX_alu_op        (alu_op),
        .ID_EX_reg_write_mux (rw_mux),
        .EX_MEM_alu_result   (o_res),
        .EX_MEM_store_data   (o_store),
        .EX_MEM_rd           (o_rd),
        .EX_MEM_instruction  (o_instr),
        .EX_MEM_mem_write    (o_mem_write),
        .EX_MEM_reg_write    (o_reg_write),
        .EX_MEM_reg_write_mux(o_rw_mux),
        .flag_c              (o_c),
        .flag_z              (o_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; a = 0; b = 0; instr = 0;
        mem_write = 0; reg_write = 0; use_carry = 0; alu_in_mux = 0;
        select_c = 0; select_z = 0; write_c = 0; write_z = 0; alu_op = 3'b000; rw_mux = 2'b00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two cycles with busy, non-zero inputs.
        clear_inputs();
        reset = 1; a = 8'hAA; b = 8'h55; instr = 19'h7FFFF; mem_write = 1; reg_write = 1;
        write_c = 1; write_z = 1; select_c = 0; select_z = 0; rw_mux = 2'b11;
        step(); step();
        chk("rst_res",   32'(o_res), 32'h0);
        chk("rst_store", 32'(o_store), 32'h0);
        chk("rst_rd",    32'(o_rd), 32'h0);
        chk("rst_instr", 32'(o_instr), 32'h0);
        chk("rst_ctrl",  32'({o_mem_write, o_reg_write, o_rw_mux}), 32'h0);
        chk("rst_flags", 32'({o_c, o_z}), 32'h0);

        // ADD with carry out: F0 + 20 = 0x110.
        reset = 0; clear_inputs();
        a = 8'hF0; b = 8'h20; instr = 19'h2800; alu_op = 3'b000;
        write_c = 1; write_z = 1; select_c = 1; select_z = 1;
        reg_write = 1; mem_write = 1; rw_mux = 2'b01;
        step();
        chk("add_res",   32'(o_res), 32'h10);
        chk("add_c",     32'(o_c), 32'h1);
        chk("add_z",     32'(o_z), 32'h0);
        chk("add_rd",    32'(o_rd), 32'h5);
        chk("add_store", 32'(o_store), 32'h20);
        chk("add_instr", 32'(o_instr), 32'h2800);
        chk("add_ctrl",  32'({o_mem_write, o_reg_write, o_rw_mux}), 32'b1101);

        // Back-to-back ADC consumes C=1: 1 + 1 + 1 = 3.
        a = 8'h01; b = 8'h01; use_carry = 1; instr = 19'h0;
        step();
        chk("adc_res", 32'(o_res), 32'h03);
        chk("adc_c",   32'(o_c), 32'h0);

        // SUB with immediate: 5 - 5 = 0.
        use_carry = 0; a = 8'h05; b = 8'hEE; alu_in_mux = 1; instr = 19'h00005; alu_op = 3'b001;
        step();
        chk("subi_res", 32'(o_res), 32'h00);
        chk("subi_z",   32'(o_z), 32'h1);
        chk("subi_c",   32'(o_c), 32'h0);

        // SUB with borrow: 3 - 5 = 0xFE.
        alu_in_mux = 0; a = 8'h03; b = 8'h05; instr = 19'h0;
        step();
        chk("subb_res", 32'(o_res), 32'hFE);
        chk("subb_c",   32'(o_c), 32'h1);
        chk("subb_z",   32'(o_z), 32'h0);

        // Stall two cycles with changing inputs: everything frozen.
        stall = 1; a = 8'h11; b = 8'h22; alu_op = 3'b000; instr = 19'h3800;
        step();
        a = 8'h00; b = 8'h00;
        step();
        chk("stall_res",   32'(o_res), 32'hFE);
        chk("stall_store", 32'(o_store), 32'h05);
        chk("stall_flags", 32'({o_c, o_z}), 32'b10);

        // Flush (with stall still high): bubble, flags held.
        flush = 1; reg_write = 1; mem_write = 1; write_c = 1; write_z = 1; rw_mux = 2'b10;
        step();
        chk("flush_ctrl",  32'({o_mem_write, o_reg_write, o_rw_mux}), 32'h0);
        chk("flush_data",  32'({o_res, o_store, o_rd}), 32'h0);
        chk("flush_instr", 32'(o_instr), 32'h0);
        chk("flush_flags", 32'({o_c, o_z}), 32'b10);

        // Explicit flag writes via instruction[0].
        clear_inputs();
        a = 8'h01; b = 8'h01; write_c = 1; select_c = 0; instr = 19'h00000;
        step();
        chk("clrc_c",   32'(o_c), 32'h0);
        chk("clrc_res", 32'(o_res), 32'h02);
        instr = 19'h00001;
        step();
        chk("setc_c", 32'(o_c), 32'h1);
        write_c = 0; instr = 19'h00000;
        step();
        chk("hold_c", 32'(o_c), 32'h1);
        chk("hold_z", 32'(o_z), 32'h0);

        // Op 111 with C=1, A=0x81.
        a = 8'h81; b = 8'h00; alu_op = 3'b111; write_c = 1; select_c = 1;
        step();
`ifdef ALU_SHIFT_EN
        chk("rorc_res", 32'(o_res), 32'hC0);
        chk("rorc_c",   32'(o_c), 32'h1);
`else
        chk("op7_res", 32'(o_res), 32'h81);
        chk("op7_c",   32'(o_c), 32'h0);
`endif

        // Logic op then reset mid-stream discards the in-flight instruction.
        clear_inputs();
        a = 8'hF0; b = 8'h3C; alu_op = 3'b100; reg_write = 1; write_z = 1; select_z = 1;
        step();
        chk("xor_res", 32'(o_res), 32'hCC);
        a = 8'h0F; alu_op = 3'b011; reset = 1;
        step();
        chk("rst2_res",  32'(o_res), 32'h0);
        chk("rst2_ctrl", 32'({o_mem_write, o_reg_write, o_rw_mux}), 32'h0);
        chk("rst2_flags", 32'({o_c, o_z}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
